// File: rtl/arb_mux_pkg.sv
// Shared constants and types for the N-channel arbitrating multiplexer.
package arb_mux_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Width of a channel index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Grant generator: fixed-priority or round-robin search starting at ptr.
// The grant is one-hot, or zero only when no channel is requesting.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int MODE = ARB_RR,
  localparam int IW  = idx_w(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [NCH-1:0] grant
);

  logic          found;
  int            base;
  logic [IW-1:0] sel;

  // Walk channels upward from the search base with wrap; first requester wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    base  = 0;
    sel   = '0;
    if (MODE == ARB_RR) base = int'(ptr);
    for (int k = 0; k < NCH; k++) begin
      sel = IW'((base + k) % NCH);
      if (!found && req[sel]) begin
        grant[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// N-channel arbitrating multiplexer with a single registered output slot.
// A granted channel is accepted whenever the slot is empty or draining, so
// a continuously ready sink sees one word per cycle with no bubbles.
module arb_mux_n
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int MODE  = ARB_RR,
  localparam int IW   = idx_w(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [IW-1:0]        out_ch,
  input  logic                 out_ready
);

  out_state_e       state_q;
  out_state_e       state_d;
  logic [IW-1:0]    rr_ptr;
  logic [NCH-1:0]   grant;
  logic [IW-1:0]    gnt_idx;
  logic [WIDTH-1:0] sel_data;
  logic             can_load;
  logic             load;
  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic [IW-1:0]    ch_p1;

  rr_arbiter #(
    .NCH  (NCH),
    .MODE (MODE)
  ) u_arb (
    .req   (in_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // ---- stage p0: grant, index encode and one-hot AND-OR data select ----
  // Encode the granted index and pick its word; grant is one-hot so OR is safe.
  always_comb begin
    gnt_idx  = '0;
    sel_data = '0;
    for (int i = 0; i < NCH; i++) begin
      sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
      if (grant[i]) gnt_idx = gnt_idx | IW'(i);
    end
  end

  assign vld_p1   = (state_q == ST_FULL);
  assign can_load = !vld_p1 || out_ready;
  // Held low during reset so no word is accepted into a slot being cleared.
  assign in_ready = grant & {NCH{can_load & rst_n}};
  assign load     = |in_ready;

  // Output slot next state: load keeps it full, a drain without load empties it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (load) state_d = ST_FULL;
      ST_FULL: begin
        if (load)           state_d = ST_FULL;
        else if (out_ready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Output slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Round-robin pointer moves past the winner only when a word is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rr_ptr <= '0;
    else if (load) rr_ptr <= (gnt_idx == IW'(NCH - 1)) ? '0 : gnt_idx + IW'(1);
  end

  // ---- stage p1: registered output word and source channel ----
  // Capture the selected word on accept; otherwise hold the last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1 <= '0;
      ch_p1   <= '0;
    end else if (load) begin
      data_p1 <= sel_data;
      ch_p1   <= gnt_idx;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_ch    = ch_p1;

endmodule

// File: tb/tb_arb_mux_n.sv
// Self-checking bench for arb_mux_n: a round-robin and a fixed-priority
// instance share the same stimulus; each has its own expected in_ready column
// and its own scoreboard queue of words that must appear at the output.
module tb_arb_mux_n;
  import arb_mux_pkg::*;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic           out_ready;

  logic [N-1:0] rdy [2];
  logic         ov  [2];
  logic [W-1:0] od  [2];
  logic [1:0]   oc  [2];

  arb_mux_n #(.WIDTH(W), .NCH(N), .MODE(ARB_RR)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[0]), .out_valid(ov[0]), .out_data(od[0]), .out_ch(oc[0]),
    .out_ready(out_ready)
  );

  arb_mux_n #(.WIDTH(W), .NCH(N), .MODE(ARB_FIXED)) u_fp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[1]), .out_valid(ov[1]), .out_data(od[1]), .out_ch(oc[1]),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic [1:0]   ch;
  } exp_t;

  typedef struct packed {
    logic [3:0] v;
    logic       ordy;
    logic [3:0] er;   // expected in_ready, round-robin instance
    logic [3:0] ef;   // expected in_ready, fixed-priority instance
  } vec_t;

  exp_t q_rr[$];
  exp_t q_fp[$];
  exp_t last [2];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] dflt_data(input int c);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'((c % 16) * 16 + i);
    return r;
  endfunction

  function automatic logic [1:0] oh2i(input logic [3:0] oh);
    case (oh)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q_rr.size() : q_fp.size();
  endfunction

  // One clock: drive, check in_ready, compare drained word, push accepted word.
  task automatic step(input string tag, input logic [3:0] v, input logic [N*W-1:0] d,
                      input logic ordy, input logic [3:0] er, input logic [3:0] ef);
    logic [3:0] e [2];
    logic       drain [2];
    exp_t       w;
    exp_t       p;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    cyc++;
    #1;
    e[0] = er;
    e[1] = ef;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s in_ready[%0d]", tag, k), 32'(rdy[k]), 32'(e[k]));
      drain[k] = (qsize(k) != 0) && ordy;
      if (drain[k]) begin
        p = (k == 0) ? q_rr.pop_front() : q_fp.pop_front();
        chk($sformatf("%s drained data[%0d]", tag, k), 32'(od[k]), 32'(p.d));
        chk($sformatf("%s drained ch[%0d]", tag, k), 32'(oc[k]), 32'(p.ch));
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (e[k] != 4'b0000) begin
        w.ch = oh2i(e[k]);
        w.d  = d[w.ch*W +: W];
        if (k == 0) q_rr.push_back(w);
        else        q_fp.push_back(w);
        last[k] = w;
      end
      chk($sformatf("%s out_valid[%0d]", tag, k), 32'(ov[k]), 32'(qsize(k) != 0));
      chk($sformatf("%s out_data[%0d]", tag, k), 32'(od[k]), 32'(last[k].d));
      chk($sformatf("%s out_ch[%0d]", tag, k), 32'(oc[k]), 32'(last[k].ch));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    // Round-robin sweep with all channels requesting
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 4'b0001};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 4'b0001};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 4'b0001};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 4'b0001};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 4'b0001};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 4'b0001};
    // Channels 1 and 2 requesting, then only channel 2
    tbl[6]  = '{4'b0110, 1'b1, 4'b0100, 4'b0010};
    tbl[7]  = '{4'b0110, 1'b1, 4'b0010, 4'b0010};
    tbl[8]  = '{4'b0110, 1'b1, 4'b0100, 4'b0010};
    tbl[9]  = '{4'b0100, 1'b1, 4'b0100, 4'b0100};
    tbl[10] = '{4'b0100, 1'b1, 4'b0100, 4'b0100};
    // Drain to empty, then reload leaving rr_ptr at 3
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 4'b0000};
    tbl[12] = '{4'b0100, 1'b0, 4'b0100, 4'b0100};
    // Wrap: ch3 loads during the drain, then ch0 is next
    tbl[13] = '{4'b1001, 1'b1, 4'b1000, 4'b0001};
    tbl[14] = '{4'b1001, 1'b1, 4'b0001, 4'b0001};

    last[0] = '0;
    last[1] = '0;

    // Reset with busy inputs
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    in_data   = 32'hDEADBEEF;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset out_valid[%0d]", k), 32'(ov[k]), 32'd0);
      chk($sformatf("reset out_data[%0d]", k), 32'(od[k]), 32'd0);
      chk($sformatf("reset out_ch[%0d]", k), 32'(oc[k]), 32'd0);
      chk($sformatf("reset in_ready[%0d]", k), 32'(rdy[k]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++)
      step($sformatf("vec%0d", i), tbl[i].v, dflt_data(cyc), tbl[i].ordy, tbl[i].er, tbl[i].ef);

    // Backpressure: hold A5 for five cycles while inputs churn
    step("bp_load", 4'b0010, {4{8'hA5}}, 1'b1, 4'b0010, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      step("bp_hold", 4'b1111, 32'($urandom), 1'b0, 4'b0000, 4'b0000);
      chk("bp_data_rr", 32'(od[0]), 32'hA5);
      chk("bp_data_fp", 32'(od[1]), 32'hA5);
    end
    // rr_ptr was 2 before the stall, so channel 2 must win now
    step("bp_release", 4'b1111, dflt_data(cyc), 1'b1, 4'b0100, 4'b0001);
    step("drain_empty", 4'b0000, dflt_data(cyc), 1'b1, 4'b0000, 4'b0000);

    // Mid-operation reset while full
    step("pre_rst", 4'b0100, dflt_data(cyc), 1'b0, 4'b0100, 4'b0100);
    in_valid = 4'b1111;
    #3;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("midrst out_valid[%0d]", k), 32'(ov[k]), 32'd0);
      chk($sformatf("midrst out_data[%0d]", k), 32'(od[k]), 32'd0);
      chk($sformatf("midrst out_ch[%0d]", k), 32'(oc[k]), 32'd0);
      chk($sformatf("midrst in_ready[%0d]", k), 32'(rdy[k]), 32'd0);
    end
    #2;
    rst_n = 1'b1;
    q_rr.delete();
    q_fp.delete();
    last[0] = '0;
    last[1] = '0;
    step("post_rst", 4'b1111, dflt_data(cyc), 1'b1, 4'b0001, 4'b0001);
    step("end_drain", 4'b0000, dflt_data(cyc), 1'b1, 4'b0000, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
